// File: rtl/ex_alu_arb.sv
// rtl/ex_alu_arb.sv - two-port arbiter/sequencer for the shared EX-stage ALU
//
// Purpose: lets port 0 (main pipeline) and port 1 (helper requester) take turns
// on one external combinational ALU. Each port has a valid/ready request channel
// and a one-entry registered valid/ready response slot.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   reqN_valid/ready              request handshake, port N
//   reqN_is_signed/op/a/b         request fields, port N
//   rspN_valid/ready              response handshake, port N
//   rspN_result/branch            captured ALU outputs, port N
//   alu_is_signed/op/a/b          drive the external ALU inputs
//   alu_result/branch             external ALU outputs
//   grant                         one-hot granted port, 00 when idle
//
// Parameter FIXED_PRIO: 0 = round-robin, 1 = port 0 always wins.

`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_AND
`define ALU_AND 4'd2
`endif
`ifndef ALU_OR
`define ALU_OR  4'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR 4'd4
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd5
`endif
`ifndef ALU_SRL
`define ALU_SRL 4'd6
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'd7
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'd8
`endif
`ifndef ALU_BEQ
`define ALU_BEQ 4'd9
`endif
`ifndef ALU_BNE
`define ALU_BNE 4'd10
`endif
`ifndef ALU_BLT
`define ALU_BLT 4'd11
`endif
`ifndef ALU_BGE
`define ALU_BGE 4'd12
`endif

module ex_alu_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_is_signed,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_is_signed,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_branch,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_branch,

    output logic        alu_is_signed,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_branch,

    output logic [1:0]  grant
);

    // Most recently accepted port; 1 out of reset so port 0 wins first contention.
    logic last;

    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;

    // A port may only be granted when its response slot is free or draining
    // this edge, so a stalled consumer never blocks the other port.
    always_comb begin
        elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
        elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        // No grants while reset is asserted: nothing can be accepted then.
        if (rst_n) begin
            if (elig0 && elig1) begin
                if ((FIXED_PRIO != 0) || last) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign grant      = {gnt1, gnt0};
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ALU operand mux; idle drives a harmless ADD of zeros.
    always_comb begin
        alu_is_signed = 1'b0;
        alu_op        = `ALU_ADD;
        alu_a         = 32'd0;
        alu_b         = 32'd0;
        if (gnt0) begin
            alu_is_signed = req0_is_signed;
            alu_op        = req0_op;
            alu_a         = req0_a;
            alu_b         = req0_b;
        end else if (gnt1) begin
            alu_is_signed = req1_is_signed;
            alu_op        = req1_op;
            alu_a         = req1_a;
            alu_b         = req1_b;
        end
    end

    // A grant implies reqN_valid, so gntN is exactly the accept strobe.
    // Capture has priority over release so a draining slot refills in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= 32'd0;
            rsp0_branch <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= 32'd0;
            rsp1_branch <= 1'b0;
            last        <= 1'b1;
        end else begin
            if (gnt0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
                rsp0_branch <= alu_branch;
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end

            if (gnt1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
                rsp1_branch <= alu_branch;
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end

            if (gnt0) begin
                last <= 1'b0;
            end else if (gnt1) begin
                last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_arb.sv
// tb/tb_ex_alu_arb.sv - self-checking bench for ex_alu_arb

`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_AND
`define ALU_AND 4'd2
`endif
`ifndef ALU_OR
`define ALU_OR  4'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR 4'd4
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd5
`endif
`ifndef ALU_SRL
`define ALU_SRL 4'd6
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'd7
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'd8
`endif
`ifndef ALU_BEQ
`define ALU_BEQ 4'd9
`endif
`ifndef ALU_BNE
`define ALU_BNE 4'd10
`endif
`ifndef ALU_BLT
`define ALU_BLT 4'd11
`endif
`ifndef ALU_BGE
`define ALU_BGE 4'd12
`endif

module tb_ex_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_is_signed;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_is_signed;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_branch;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_branch;
    logic [31:0] rsp1_result;
    logic        alu_is_signed;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_branch;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_alu_arb #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_is_signed(req0_is_signed),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_is_signed(req1_is_signed),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_branch(rsp0_branch),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_branch(rsp1_branch),
        .alu_is_signed(alu_is_signed), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_branch(alu_branch),
        .grant(grant)
    );

    // External combinational ALU the block drives.
    always_comb begin
        alu_result = 32'd0;
        alu_branch = 1'b0;
        case (alu_op)
            `ALU_ADD: alu_result = alu_a + alu_b;
            `ALU_SUB: alu_result = alu_a - alu_b;
            `ALU_AND: alu_result = alu_a & alu_b;
            `ALU_OR:  alu_result = alu_a | alu_b;
            `ALU_XOR: alu_result = alu_a ^ alu_b;
            `ALU_SLT: alu_result = {31'd0, alu_is_signed ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b)};
            `ALU_BEQ: alu_branch = (alu_a == alu_b);
            `ALU_BNE: alu_branch = (alu_a != alu_b);
            `ALU_BLT: alu_branch = alu_is_signed ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);
            `ALU_BGE: alu_branch = alu_is_signed ? ($signed(alu_a) >= $signed(alu_b)) : (alu_a >= alu_b);
            default:  alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] r;
        logic        b;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        br;
    } vec_t;

    vec_t vecs[12];

    // Load a request onto a port and push its expected response.
    task automatic drive(input logic p, input logic [3:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic br);
        exp_t e;
        e.r = r;
        e.b = br;
        if (!p) begin
            req0_op = op; req0_is_signed = sg; req0_a = a; req0_b = b; req0_valid = 1'b1;
            q0.push_back(e);
        end else begin
            req1_op = op; req1_is_signed = sg; req1_a = a; req1_b = b; req1_valid = 1'b1;
            q1.push_back(e);
        end
    endtask

    // Response monitor: scoreboard pop on consume, plus hold-stability check.
    exp_t        e0, e1;
    logic        prev_rst = 1'b0;
    logic        p0_v = 1'b0, p0_rdy = 1'b0, p1_v = 1'b0, p1_rdy = 1'b0;
    logic [31:0] p0_r = 32'd0, p1_r = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (prev_rst && p0_v && !p0_rdy) begin
                chk("rsp0_hold_valid", {31'd0, rsp0_valid}, 32'd1);
                chk("rsp0_hold_result", rsp0_result, p0_r);
            end
            if (prev_rst && p1_v && !p1_rdy) begin
                chk("rsp1_hold_valid", {31'd0, rsp1_valid}, 32'd1);
                chk("rsp1_hold_result", rsp1_result, p1_r);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp0_unexpected: got=%h expected=no response", rsp0_result);
                end else begin
                    e0 = q0.pop_front();
                    chk("rsp0_result", rsp0_result, e0.r);
                    chk("rsp0_branch", {31'd0, rsp0_branch}, {31'd0, e0.b});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp1_unexpected: got=%h expected=no response", rsp1_result);
                end else begin
                    e1 = q1.pop_front();
                    chk("rsp1_result", rsp1_result, e1.r);
                    chk("rsp1_branch", {31'd0, rsp1_branch}, {31'd0, e1.b});
                end
            end
        end
        prev_rst = rst_n;
        p0_v = rsp0_valid; p0_rdy = rsp0_ready; p0_r = rsp0_result;
        p1_v = rsp1_valid; p1_rdy = rsp1_ready; p1_r = rsp1_result;
    end

    logic [1:0] rr_exp [4];

    initial begin
        vecs[0]  = '{1'b0, `ALU_ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, `ALU_SUB, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{1'b0, `ALU_AND, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
        vecs[3]  = '{1'b1, `ALU_OR,  1'b0, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b0, `ALU_XOR, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
        vecs[5]  = '{1'b0, `ALU_SLT, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vecs[6]  = '{1'b1, `ALU_SLT, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, `ALU_BEQ, 1'b0, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, `ALU_BNE, 1'b0, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, `ALU_BGE, 1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[10] = '{1'b1, `ALU_BLT, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, `ALU_BLT, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_is_signed = 1'b0; req0_op = `ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_is_signed = 1'b0; req1_op = `ALU_ADD; req1_a = 32'd3; req1_b = 32'd4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset held two cycles with both requests valid.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_grant", {30'd0, grant}, 32'd0);
            chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
            chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
            chk("rst_rsp0_result", rsp0_result, 32'd0);
            chk("rst_rsp1_result", rsp1_result, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("first_grant", {30'd0, grant}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("idle_grant", {30'd0, grant}, 32'd0);
        chk("idle_alu_op", {28'd0, alu_op}, {28'd0, `ALU_ADD});
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_alu_signed", {31'd0, alu_is_signed}, 32'd0);

        // Single-port add with response timing.
        @(posedge clk); #1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive(1'b0, `ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge clk);
        chk("add_grant", {30'd0, grant}, 32'd1);
        chk("add_alu_a", alu_a, 32'd5);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("add_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("add_rsp_result", rsp0_result, 32'd12);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_rsp_clear", {31'd0, rsp0_valid}, 32'd0);

        // Table: streaming one request per cycle on the listed port.
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            drive(vecs[i].port, vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), {30'd0, grant}, vecs[i].port ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;

        // Round-robin with both ports continuously valid.
        drive(1'b0, `ALU_SUB, 1'b0, 32'd10, 32'd3, 32'd7, 1'b0);
        drive(1'b1, `ALU_XOR, 1'b0, 32'hF0, 32'hFF, 32'h0F, 1'b0);
        q0.push_back(q0[q0.size()-1]);
        q1.push_back(q1[q1.size()-1]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", i), {30'd0, grant}, {30'd0, rr_exp[i]});
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure bypass: port 0 slot full and stalled, port 1 streams.
        rsp0_ready = 1'b0;
        drive(1'b0, `ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        chk("bp_fill_grant", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, `ALU_ADD, 1'b0, 32'd4, 32'd4, 32'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, `ALU_OR, 1'b0, 32'h100, 32'(i), 32'h100 | 32'(i), 1'b0);
            @(negedge clk);
            chk($sformatf("bp_grant%0d", i), {30'd0, grant}, 32'd2);
            chk($sformatf("bp_req0_ready%0d", i), {31'd0, req0_ready}, 32'd0);
            chk($sformatf("bp_rsp0_result%0d", i), rsp0_result, 32'd3);
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Both slots full and stalled: no grant until one drains.
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drive(1'b0, `ALU_ADD, 1'b0, 32'h10, 32'h1, 32'h11, 1'b0);
        drive(1'b1, `ALU_ADD, 1'b0, 32'h20, 32'h2, 32'h22, 1'b0);
        @(negedge clk);
        chk("full_grant_a", {30'd0, grant}, 32'd2);
        @(posedge clk); #1;
        drive(1'b1, `ALU_ADD, 1'b0, 32'h30, 32'h3, 32'h33, 1'b0);
        @(negedge clk);
        chk("full_grant_b", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, `ALU_ADD, 1'b0, 32'h40, 32'h4, 32'h44, 1'b0);
        @(negedge clk);
        chk("full_grant_none", {30'd0, grant}, 32'd0);
        @(posedge clk); #1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        chk("full_drain_grant_d", {30'd0, grant}, 32'd2);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("full_drain_grant_e", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mid-operation reset discards a held port 1 response.
        rsp1_ready = 1'b0;
        drive(1'b1, `ALU_ADD, 1'b0, 32'd9, 32'd9, 32'd18, 1'b0);
        @(negedge clk);
        chk("mr_grant", {30'd0, grant}, 32'd2);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("mr_held_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("mr_held_result", rsp1_result, 32'd18);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mr_rsp1_valid%0d", i), {31'd0, rsp1_valid}, 32'd0);
            chk($sformatf("mr_rsp1_result%0d", i), rsp1_result, 32'd0);
            @(posedge clk); #1;
        end

        @(negedge clk);
        chk("sb_q0_empty", q0.size(), 32'd0);
        chk("sb_q1_empty", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_alu_arb.md
# ex_alu_arb

Two-port arbiter and sequencer for the shared EX-stage integer ALU. It lets the main pipeline (port 0) and a secondary requester, such as a branch-target or CSR helper (port 1), issue operations to one combinational ALU instance. Each port gets a valid/ready request channel and a registered valid/ready response channel. The ALU is instantiated outside this block; the block drives its operand and opcode inputs and captures its `result` and `branch` outputs.

## Interface
- `FIXED_PRIO`, default 0. Selects the arbitration policy.
  - 0: round-robin.
  - 1: port 0 always wins.
- `clk`  in  1  Clock. Everything is sampled on the rising edge.
- `rst_n`  in  1  Reset. One clock; reset is synchronous and active-low.
- `reqN_valid`  in  1  Request present on port N (N = 0, 1).
- `reqN_ready`  out  1  Port N's request is accepted this cycle.
- `reqN_is_signed`  in  1  Signed compare select.
- `reqN_op`  in  4  ALU opcode, using the `ALU_*` defines.
- `reqN_a`, `reqN_b`  in  32  Operands.
- `rspN_valid`  out  1  Response held for port N.
- `rspN_ready`  in  1  Port N consumes its response.
- `rspN_result`  out  32  Captured ALU result.
- `rspN_branch`  out  1  Captured branch decision.
- `alu_is_signed`  out  1  Drives the ALU signed select.
- `alu_op`  out  4  Drives the ALU opcode.
- `alu_a`, `alu_b`  out  32  Drive the ALU operands.
- `alu_result`  in  32  Result from the ALU.
- `alu_branch`  in  1  Branch decision from the ALU.
- `grant`  out  2  One-hot port granted this cycle; 00 when idle.

## Operation
**Eligibility**
- Port N is eligible when `reqN_valid` is high and its response slot can take data: `!rspN_valid || rspN_ready`.

**Arbitration**
- At most one grant per cycle.
- If only one port is eligible, it is granted.
- If both are eligible:
  - `FIXED_PRIO=1`: port 0 is granted.
  - `FIXED_PRIO=0`: the port other than `last` is granted.
- `last` is a 1-bit register. It records the most recently accepted port and updates only on acceptance.
- A port whose response slot is full and not draining is never granted; the other eligible port gets the ALU instead (no head-of-line blocking).

**Outputs while granted**
- `reqN_ready` = `grant[N]`.
- The ALU inputs mux the granted port's `is_signed`, `op`, `a` and `b`.

**Outputs while idle**
- `alu_op` = `ALU_ADD`, `alu_a` = 0, `alu_b` = 0, `alu_is_signed` = 0.

**Capture**
- On the edge where `reqN_valid && reqN_ready`, `alu_result` and `alu_branch` are registered into `rspN_result` and `rspN_branch`, and `rspN_valid` is set.

**Response hold and release**
- `rspN_valid`, `rspN_result` and `rspN_branch` stay stable while `rspN_valid && !rspN_ready`.
- `rspN_valid` clears on `rspN_ready` unless a new capture happens on the same edge. In that case valid stays 1 and the data is replaced (back-to-back streaming).

**Ports are independent**
- Each response slot holds exactly one entry; no reordering is possible.

**Requester obligations**
- `reqN_valid` must not depend on `reqN_ready`.
- Request fields must be held stable while valid and not ready.
- `rspN_ready` must not depend combinationally on `reqN_*`. This guarantees there is no combinational loop.

## Timing
**Reset**
- On any edge with `rst_n`=0:
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp*_result` = 0 and `rsp*_branch` = 0.
  - `last` = 1, so port 0 wins the first contention.
- Combinational outputs with both request valids low:
  - `grant` = 00, `req*_ready` = 0.
  - ALU inputs at the idle values.
- Reset mid-operation discards held responses; no data is delivered after reset.

**Latency**
- Request accepted at edge T: `rspN_valid` = 1 and the data is valid from edge T onward, visible in cycle T+1.
- Earliest consume is edge T+1.

**Throughput**
- Aggregate: one operation per cycle.
- Single port streaming with `rspN_ready`=1: one operation per cycle.
- Both ports continuously eligible under round-robin: strict alternation 0,1,0,1…

**Combinational paths**
- `grant`, `req*_ready` and the ALU inputs are combinational from `req*_valid`, `rsp*_valid`, `rsp*_ready` and `last`.
- The ALU path is combinational from the ALU inputs to the capture registers: a single-cycle path.

**Simultaneous events**
- Both valid while port 0's slot is full and `rsp0_ready`=0: grant port 1.
- Both valid and both slots full and not draining: grant 00 and hold the state.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with both requests valid. Required: `grant`=00, `rsp*_valid`=0, `rsp*_result`=0 after every edge. Release reset; the first grant is port 0.
- **Single-port add:** port 0 `ALU_ADD`, a=5, b=7, `rsp0_ready`=1. Required:
  - `grant`=01 in the same cycle.
  - Next cycle, `rsp0_valid`=1 and `rsp0_result`=12.
  - Then `rsp0_valid`=0.
- **Round-robin:** both ports valid for 4 cycles; port 0 `ALU_SUB` 10-3, port 1 `ALU_XOR` 0xF0^0xFF; both ready=1. Required:
  - Grants 01,10,01,10.
  - `rsp0_result`=7 and `rsp1_result`=0x0F, each on alternate cycles.
- **Backpressure bypass:** fill port 0's slot and hold `rsp0_ready`=0. Issue port 0 and port 1 requests. Required:
  - Port 1 is granted every cycle; port 0 `reqN_ready`=0.
  - `rsp0_result` is unchanged until `rsp0_ready`=1.
- **Branch capture:** port 1 `ALU_BLT`, `is_signed`=1, a=0xFFFFFFFF, b=1. Required: `rsp1_branch`=1. The same operands with `is_signed`=0 give `rsp1_branch`=0.
- **Mid-operation reset:** with `rsp1_valid`=1 held, assert `rst_n`=0 for 1 cycle. Required: `rsp1_valid`=0 after the edge, and no stale result after release.
